// File: rtl/mod_addsub_seq.sv
// mod_addsub_seq
// Limb-serial modular adder/subtractor: sum = (a + b) mod P or (a - b) mod P.
// One LIMB-bit slice is processed per clock, LSB limb first. Two chains run
// side by side on each limb: chain 1 forms the raw result r = a +/- b, and
// chain 2 forms the corrected result q = r -/+ P. Once all limbs are done,
// the final carry/borrow bits decide whether q or r is the reduced result.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only while idle
//   op     in   0 = add, 1 = subtract (captured with start)
//   a, b   in   WIDTH-bit operands, expected < P (captured with start)
//   busy   out  high while an operation is in flight
//   done   out  one-cycle pulse; sum is valid in that cycle
//   sum    out  WIDTH-bit result, held from one done until the next done
module mod_addsub_seq #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64,
  parameter logic [WIDTH-1:0] P =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum
);

  localparam int NLIMB = WIDTH / LIMB;
  localparam int IW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] a_r, b_r, p_r;       // operand/modulus shifters, limb 0 at LSB
  logic [WIDTH-1:0] r_r, q_r;            // raw and corrected result shifters
  logic             op_r;
  logic             c1_r;                // chain 1 carry (add) or borrow (sub)
  logic             c2_r;                // chain 2 borrow (add) or carry (sub)
  logic [IW-1:0]    idx_r;

  logic [LIMB-1:0]  a_l_s, b_l_s, p_l_s, r_l_s;
  logic [LIMB:0]    ch1_s, ch2_s;
  logic [WIDTH-1:0] a_nx_s, b_nx_s, p_nx_s, r_nx_s, q_nx_s;
  logic             busy_nx_s, done_nx_s, sel_q_s;
  logic [WIDTH-1:0] sum_nx_s;

  // Limb arithmetic for both chains plus the next values of every shifter.
  always_comb begin
    a_l_s = a_r[LIMB-1:0];
    b_l_s = b_r[LIMB-1:0];
    p_l_s = p_r[LIMB-1:0];
    if (!op_r) begin
      ch1_s = {1'b0, a_l_s} + {1'b0, b_l_s} + {{LIMB{1'b0}}, c1_r};
    end else begin
      ch1_s = {1'b0, a_l_s} - {1'b0, b_l_s} - {{LIMB{1'b0}}, c1_r};
    end
    r_l_s = ch1_s[LIMB-1:0];
    // Chain 2 consumes this cycle's raw limb, so both chains settle together.
    if (!op_r) begin
      ch2_s = {1'b0, r_l_s} - {1'b0, p_l_s} - {{LIMB{1'b0}}, c2_r};
    end else begin
      ch2_s = {1'b0, r_l_s} + {1'b0, p_l_s} + {{LIMB{1'b0}}, c2_r};
    end
    // Concatenate-and-shift keeps the shifters legal when LIMB == WIDTH.
    a_nx_s = WIDTH'({{LIMB{1'b0}}, a_r} >> LIMB);
    b_nx_s = WIDTH'({{LIMB{1'b0}}, b_r} >> LIMB);
    p_nx_s = WIDTH'({{LIMB{1'b0}}, p_r} >> LIMB);
    r_nx_s = WIDTH'({r_l_s, r_r} >> LIMB);
    q_nx_s = WIDTH'({ch2_s[LIMB-1:0], q_r} >> LIMB);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_RUN;
        else       state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (idx_r == IW'(NLIMB - 1)) state_nx_s = ST_DONE;
        else                         state_nx_s = ST_RUN;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode; outputs are registered so done/busy/sum are glitch-free.
  always_comb begin
    busy_nx_s = (state_nx_s != ST_IDLE);
    done_nx_s = (state_r == ST_DONE);
    // add: q when a+b >= P (carry out, or no borrow subtracting P)
    // sub: q when a < b (final borrow out of chain 1)
    if (op_r) sel_q_s = c1_r;
    else      sel_q_s = c1_r | ~c2_r;
    if (done_nx_s) sum_nx_s = sel_q_s ? q_r : r_r;
    else           sum_nx_s = sum;
  end

  // Operand capture and limb-serial datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      p_r   <= {WIDTH{1'b0}};
      r_r   <= {WIDTH{1'b0}};
      q_r   <= {WIDTH{1'b0}};
      op_r  <= 1'b0;
      c1_r  <= 1'b0;
      c2_r  <= 1'b0;
      idx_r <= {IW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            p_r   <= P;
            op_r  <= op;
            c1_r  <= 1'b0;
            c2_r  <= 1'b0;
            idx_r <= {IW{1'b0}};
          end
        end
        ST_RUN: begin
          a_r   <= a_nx_s;
          b_r   <= b_nx_s;
          p_r   <= p_nx_s;
          r_r   <= r_nx_s;
          q_r   <= q_nx_s;
          c1_r  <= ch1_s[LIMB];
          c2_r  <= ch2_s[LIMB];
          idx_r <= idx_r + IW'(1);
        end
        default: begin
          // DONE holds everything while the final select is registered.
        end
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= {WIDTH{1'b0}};
    end else begin
      busy <= busy_nx_s;
      done <= done_nx_s;
      sum  <= sum_nx_s;
    end
  end

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Self-checking bench for mod_addsub_seq: directed vectors with literal
// expectations plus randomized vectors against a plain-arithmetic model
// that also tracks the expected busy/done/sum values on every cycle.
module tb_mod_addsub_seq;

  localparam int WIDTH = 256;
  localparam int LIMB  = 64;
  localparam int NL    = WIDTH / LIMB;
  localparam logic [WIDTH-1:0] PM =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done;
  logic [WIDTH-1:0] sum;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  mod_addsub_seq #(.WIDTH(WIDTH), .LIMB(LIMB), .P(PM)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum)
  );

  always #5 clk = ~clk;

  // Reference result straight from modular arithmetic.
  function automatic logic [WIDTH-1:0] golden(input logic o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH:0] t;
    if (!o) begin
      t = {1'b0, x} + {1'b0, y};
      if (t >= {1'b0, PM}) t = t - {1'b0, PM};
    end else if (x >= y) begin
      t = {1'b0, x} - {1'b0, y};
    end else begin
      t = {1'b0, x} + {1'b0, PM} - {1'b0, y};
    end
    return t[WIDTH-1:0];
  endfunction

  // Random operand below P, biased toward the ends of the range.
  function automatic logic [WIDTH-1:0] rnd();
    logic [WIDTH-1:0] v;
    int mode;
    v = '0;
    for (int k = 0; k < WIDTH / 32; k++) v = {v[WIDTH-33:0], 32'($urandom)};
    mode = $urandom_range(0, 7);
    if (mode == 0)      v = PM - WIDTH'($urandom_range(1, 4));
    else if (mode == 1) v = WIDTH'($urandom_range(0, 4));
    else if (v >= PM)   v = v - PM;
    return v;
  endfunction

  // Cycle model: an accepted start yields done NL+1 edges later; starts while
  // an operation is pending are ignored.
  int               cd;
  logic             m_done;
  logic [WIDTH-1:0] m_sum, m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cd     <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_pend <= '0;
    end else begin
      m_done <= (cd == 1);
      if (cd == 1) m_sum <= m_pend;
      if (cd != 0) begin
        cd <= cd - 1;
      end else if (start) begin
        cd     <= NL + 1;
        m_pend <= golden(op, a, b);
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({busy, done, sum} !== {(cd != 0), m_done, m_sum}) begin
        errors++;
        $display("FAIL cycle t=%0t: busy=%b done=%b sum=%h, model busy=%b done=%b sum=%h",
                 $time, busy, done, sum, (cd != 0), m_done, m_sum);
      end
    end
  end

  // Issue one operation from a negedge; returns at the negedge showing done.
  task automatic do_op(input logic o, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] exp,
                       input bit inject, input string nm);
    int n;
    int nb;
    bit got;
    op = o; a = x; b = y; start = 1'b1;
    nb = 0;
    got = 1'b0;
    n = 0;
    @(negedge clk);
    if (busy) nb++;
    start = 1'b0; op = ~o; a = rnd(); b = rnd();
    while (!got && n < 20) begin
      if (inject && n == 1) begin
        start = 1'b1; a = rnd(); b = rnd();
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else if (busy) nb++;
    end
    start = 1'b0;
    checks++;
    if (!got || n != NL + 1) begin
      errors++;
      $display("FAIL %s latency: got=%0d done_seen=%0d required=%0d", nm, n, got, NL + 1);
    end
    checks++;
    if (nb != NL + 1) begin
      errors++;
      $display("FAIL %s busy cycles: got=%0d required=%0d", nm, nb, NL + 1);
    end
    checks++;
    if (sum !== exp) begin
      errors++;
      $display("FAIL %s sum: got=%h required=%h", nm, sum, exp);
    end
  endtask

  initial begin
    logic o;
    logic [WIDTH-1:0] x, y;
    int gap;

    repeat (3) @(negedge clk);
    started = 1'b1;
    checks++;
    if ({busy, done, sum} !== {1'b0, 1'b0, {WIDTH{1'b0}}}) begin
      errors++;
      $display("FAIL reset state: busy=%b done=%b sum=%h required all zero", busy, done, sum);
    end
    #2 rst = 1'b0;
    @(negedge clk);

    do_op(1'b0, 256'd1, 256'd2, 256'd3, 1'b0, "add_1_2");
    do_op(1'b0, PM - 256'd1, 256'd1, 256'd0, 1'b0, "add_pm1_1");
    do_op(1'b0, PM - 256'd1, PM - 256'd1, PM - 256'd2, 1'b0, "add_pm1_pm1");
    do_op(1'b1, 256'd5, 256'd7, PM - 256'd2, 1'b0, "sub_5_7");
    do_op(1'b1, 256'd7, 256'd5, 256'd2, 1'b0, "sub_7_5");
    do_op(1'b1, 256'h1_0000_0000_0000_0000, 256'd1, 256'hFFFF_FFFF_FFFF_FFFF, 1'b0, "sub_borrow");
    do_op(1'b0, 256'd10, 256'd20, 256'd30, 1'b1, "start_ignored");
    // Immediately after done: back-to-back acceptance.
    do_op(1'b1, 256'd20, 256'd10, 256'd10, 1'b0, "back_to_back");

    // Reset two cycles into RUN.
    op = 1'b0; a = 256'd100; b = 256'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sum} !== {1'b0, 1'b0, {WIDTH{1'b0}}}) begin
      errors++;
      $display("FAIL reset in run: busy=%b done=%b sum=%h required all zero", busy, done, sum);
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (NL + 3) @(negedge clk);
    do_op(1'b0, 256'd3, 256'd4, 256'd7, 1'b0, "add_after_reset");

    for (int i = 0; i < 3000; i++) begin
      o = 1'($urandom_range(0, 1));
      x = rnd();
      y = rnd();
      do_op(o, x, y, golden(o, x, y), (i % 7) == 0, "random");
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
